// File: rtl/bitcell_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bitcell_array_ctrl
//  Purpose  : Request sequencer for an SR-latch bitcell array. It decodes the
//             word address to a one-hot row select and drives a
//             setup / write-pulse / hold sequence. Select and data are always
//             stable around the rw pulse. Read data or a write acknowledge is
//             returned as a one-cycle response pulse.
//  Option   : VERIFY_WRITE_EN -- writes read back the row after HOLD and
//             flag rsp_err on mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module bitcell_array_ctrl #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 4,
  parameter int WRITE_CYCLES = 2   // 1..15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [2**ADDR_W-1:0]   cell_sel,
  output logic                   cell_rw,
  output logic [DATA_W-1:0]      cell_data,
  input  logic [DATA_W-1:0]      cell_out
);

  localparam int               WORDS    = 2**ADDR_W;
  localparam logic [3:0]       CNT_LOAD = 4'(WRITE_CYCLES - 1);
  localparam logic [WORDS-1:0] SEL_ONE  = {{(WORDS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WRITE  = 3'd2,
    S_HOLD   = 3'd3,
    S_SAMPLE = 3'd4,
    S_RESP   = 3'd5
`ifdef VERIFY_WRITE_EN
    ,
    S_VERIFY = 3'd6
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [WORDS-1:0]  cell_sel_q, cell_sel_d;
  logic              cell_rw_q, cell_rw_d;
  logic [DATA_W-1:0] cell_data_q, cell_data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef VERIFY_WRITE_EN
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  // Next-state and next-output logic. Every array-facing output is computed
  // one cycle ahead so that it can be registered and change only on an edge.
  always_comb begin
    state_d     = state_q;
    cell_sel_d  = cell_sel_q;
    cell_rw_d   = 1'b0;
    cell_data_d = cell_data_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef VERIFY_WRITE_EN
    wdata_d     = wdata_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = S_SETUP;
          we_d        = req_we;
          cell_sel_d  = SEL_ONE << req_addr;
          cell_data_d = req_we ? req_wdata : '0;
`ifdef VERIFY_WRITE_EN
          wdata_d     = req_wdata;
`endif
        end
      end
      S_SETUP: begin
        // rw rises only after sel/data have been stable for a full cycle
        if (we_q) begin
          state_d   = S_WRITE;
          cell_rw_d = 1'b1;
          cnt_d     = CNT_LOAD;
        end else begin
          state_d   = S_SAMPLE;
        end
      end
      S_WRITE: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_HOLD;
        end else begin
          cnt_d     = cnt_q - 4'd1;
          cell_rw_d = 1'b1;
        end
      end
      S_HOLD: begin
`ifdef VERIFY_WRITE_EN
        // keep the row selected to read it back; stop driving write data
        state_d     = S_VERIFY;
        cell_data_d = '0;
`else
        state_d     = S_RESP;
        cell_sel_d  = '0;
        cell_data_d = '0;
        rsp_valid_d = 1'b1;
`endif
      end
`ifdef VERIFY_WRITE_EN
      S_VERIFY: begin
        state_d     = S_RESP;
        cell_sel_d  = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = (cell_out != wdata_q);
      end
`endif
      S_SAMPLE: begin
        state_d     = S_RESP;
        cell_sel_d  = '0;
        cell_data_d = '0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cell_out;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        cell_sel_d  = '0;
        cell_data_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops rw and select immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cell_sel_q  <= '0;
      cell_rw_q   <= 1'b0;
      cell_data_q <= '0;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef VERIFY_WRITE_EN
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cell_sel_q  <= cell_sel_d;
      cell_rw_q   <= cell_rw_d;
      cell_data_q <= cell_data_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef VERIFY_WRITE_EN
      wdata_q     <= wdata_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cell_sel  = cell_sel_q;
  assign cell_rw   = cell_rw_q;
  assign cell_data = cell_data_q;
`ifdef VERIFY_WRITE_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire
